// File: rtl/microcode_sequencer_if.sv
// Sequencing bus between a microword source and the microcode sequencer.
// The master drives the per-word controls; the slave returns PC and stack status.
interface microcode_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int OFF_W  = 4,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [2:0]        op;
    logic              cond;
    logic [OFF_W-1:0]  offset;
    logic [ADDR_W-1:0] target;
    logic              trap_req;
    logic              stall;
    logic              clear_err;
    logic [ADDR_W-1:0] micro_pc;
    logic [ADDR_W-1:0] next_pc;
    logic [LVL_W-1:0]  stack_level;
    logic              stack_overflow;
    logic              stack_underflow;

    modport master (
        output op, cond, offset, target, trap_req, stall, clear_err,
        input  micro_pc, next_pc, stack_level, stack_overflow, stack_underflow
    );

    modport slave (
        input  op, cond, offset, target, trap_req, stall, clear_err,
        output micro_pc, next_pc, stack_level, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode address sequencer with a bounded return stack, trap entry and
// sticky stack error flags. Full-stack pushes drop the oldest entry.
module microcode_sequencer #(
    parameter int                ADDR_W   = 9,
    parameter int                DEPTH    = 4,
    parameter int                OFF_W    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0] TRAP_PC  = 9'h1F0
) (
    input  logic                   clock,
    input  logic                   reset,
    microcode_sequencer_if.slave   bus
);
    localparam int               LVL_W    = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        OP_NEXT   = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JUMP   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RETURN = 3'd4,
        OP_WAIT   = 3'd5,
        OP_PUSH   = 3'd6,
        OP_POP    = 3'd7
    } op_e;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [ADDR_W-1:0] stack_d [DEPTH];
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              push_s, pop_s, hold_s;
    logic              ovf_set_s, udf_set_s;
    logic [ADDR_W-1:0] push_val_s;
    logic [ADDR_W-1:0] top_s;
    logic [ADDR_W-1:0] inc_s;
    logic [ADDR_W-1:0] offset_ext_s;

    assign inc_s        = pc_q + ADDR_W'(1'b1);
    assign offset_ext_s = ADDR_W'(bus.offset);

    // Select the top-of-stack entry (index level-1); zero when empty.
    always_comb begin
        top_s = {ADDR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            top_s = (level_q == LVL_W'(i + 1)) ? stack_q[i] : top_s;
        end
    end

    // Next-address selection and stack request decode; trap beats stall beats op.
    always_comb begin
        pc_d       = inc_s;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        hold_s     = 1'b0;
        push_val_s = pc_q;
        if (bus.trap_req) begin
            pc_d       = TRAP_PC;
            push_s     = 1'b1;
            push_val_s = pc_q;
        end else if (bus.stall) begin
            pc_d   = pc_q;
            hold_s = 1'b1;
        end else begin
            case (op_e'(bus.op))
                OP_NEXT:   pc_d = inc_s;
                OP_BRANCH: pc_d = bus.cond ? (pc_q + offset_ext_s) : inc_s;
                OP_JUMP:   pc_d = bus.target;
                OP_CALL: begin
                    pc_d       = bus.target;
                    push_s     = 1'b1;
                    push_val_s = inc_s;
                end
                OP_RETURN: begin
                    pop_s = 1'b1;
                    pc_d  = (level_q != {LVL_W{1'b0}}) ? top_s : inc_s;
                end
                OP_WAIT:   pc_d = bus.cond ? inc_s : pc_q;
                OP_PUSH: begin
                    push_s     = 1'b1;
                    push_val_s = pc_q;
                end
                OP_POP:    pop_s = 1'b1;
                default:   pc_d = inc_s;
            endcase
        end
    end

    // Stack storage update; a full push shifts out the oldest entry at index 0.
    always_comb begin
        stack_d   = stack_q;
        level_d   = level_q;
        ovf_set_s = 1'b0;
        udf_set_s = 1'b0;
        if (push_s) begin
            if (level_q == FULL_LVL) begin
                ovf_set_s = 1'b1;
                for (int i = 0; i < DEPTH - 1; i++) begin
                    stack_d[i] = stack_q[i + 1];
                end
                stack_d[DEPTH-1] = push_val_s;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    stack_d[i] = (level_q == LVL_W'(i)) ? push_val_s : stack_q[i];
                end
                level_d = level_q + LVL_W'(1'b1);
            end
        end else if (pop_s) begin
            if (level_q == {LVL_W{1'b0}}) begin
                udf_set_s = 1'b1;
            end else begin
                level_d = level_q - LVL_W'(1'b1);
            end
        end else begin
            level_d = level_q;
        end
    end

    // Sticky error flags; a same-cycle error outranks clear_err, stall freezes both.
    always_comb begin
        if (hold_s) begin
            ovf_d = ovf_q;
            udf_d = udf_q;
        end else begin
            ovf_d = (ovf_q & ~bus.clear_err) | ovf_set_s;
            udf_d = (udf_q & ~bus.clear_err) | udf_set_s;
        end
    end

    // Sequencer state registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            level_q <= {LVL_W{1'b0}};
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            pc_q    <= pc_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            stack_q <= stack_d;
        end
    end

    assign bus.micro_pc        = pc_q;
    assign bus.next_pc         = reset ? RESET_PC : pc_d;
    assign bus.stack_level     = level_q;
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = udf_q;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_microcode_sequencer;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 4;
    localparam int OFF_W  = 4;
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int TRAP   = 'h1F0;
    localparam int MASK   = 'h1FF;

    logic clock;
    logic reset;

    microcode_sequencer_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .DEPTH(DEPTH)) bus ();

    microcode_sequencer #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .OFF_W(OFF_W),
        .RESET_PC(9'h000), .TRAP_PC(9'h1F0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: PC as an integer, stack as a queue (back = top).
    int m_pc;
    int m_stack[$];
    bit m_ovf, m_udf;
    bit raised_o, raised_u;

    function automatic int predict_next();
        int o = int'(bus.op);
        if (bus.trap_req) return TRAP;
        if (bus.stall) return m_pc;
        case (o)
            0: return (m_pc + 1) & MASK;
            1: return bus.cond ? ((m_pc + int'(bus.offset)) & MASK) : ((m_pc + 1) & MASK);
            2, 3: return int'(bus.target);
            4: return (m_stack.size() > 0) ? m_stack[m_stack.size()-1] : ((m_pc + 1) & MASK);
            5: return bus.cond ? ((m_pc + 1) & MASK) : m_pc;
            default: return (m_pc + 1) & MASK;
        endcase
    endfunction

    task automatic model_push(input int v);
        if (m_stack.size() == DEPTH) begin
            void'(m_stack.pop_front());
            raised_o = 1'b1;
        end
        m_stack.push_back(v);
    endtask

    task automatic model_pop();
        if (m_stack.size() > 0) void'(m_stack.pop_back());
        else raised_u = 1'b1;
    endtask

    task automatic model_apply();
        int nxt = predict_next();
        raised_o = 1'b0;
        raised_u = 1'b0;
        if (bus.trap_req) model_push(m_pc);
        else if (!bus.stall) begin
            case (int'(bus.op))
                3: model_push((m_pc + 1) & MASK);
                4, 7: model_pop();
                6: model_push(m_pc);
                default: ;
            endcase
        end
        if (bus.trap_req || !bus.stall) begin
            m_ovf = (m_ovf && !bus.clear_err) || raised_o;
            m_udf = (m_udf && !bus.clear_err) || raised_u;
        end
        m_pc = nxt;
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic drive(input logic [2:0] op, input logic cond, input logic [OFF_W-1:0] off,
                         input logic [ADDR_W-1:0] tgt, input logic trap, input logic stl,
                         input logic clr);
        bus.op = op; bus.cond = cond; bus.offset = off; bus.target = tgt;
        bus.trap_req = trap; bus.stall = stl; bus.clear_err = clr;
    endtask

    task automatic tick();
        model_apply();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic [2:0] op, input logic [ADDR_W-1:0] tgt);
        drive(op, 1'b0, '0, tgt, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(3'd0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(3'd2, 1'b1, 4'h3, 9'h055, 1'b0, 1'b0, 1'b0);
        #2;
        n_checks++;
        if (bus.micro_pc !== 9'h000) begin n_errors++; $display("FAIL reset_pc got %h exp 000", bus.micro_pc); end
        n_checks++;
        if (bus.next_pc !== 9'h000) begin n_errors++; $display("FAIL reset_next_pc got %h exp 000", bus.next_pc); end
        n_checks++;
        if (bus.stack_level !== 3'd0 || bus.stack_overflow !== 1'b0 || bus.stack_underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_stack got lvl=%0d ovf=%b udf=%b exp 0 0 0", bus.stack_level, bus.stack_overflow, bus.stack_underflow);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        step(3'd0, '0);
        n_checks++;
        if (bus.micro_pc !== 9'h001) begin n_errors++; $display("FAIL first_edge got %h exp 001", bus.micro_pc); end
    endtask

    task automatic test_call_return();
        do_reset();
        step(3'd2, 9'h010);
        step(3'd3, 9'h080);
        n_checks++;
        if (bus.micro_pc !== 9'h080 || bus.stack_level !== 3'd1) begin
            n_errors++; $display("FAIL call got pc=%h lvl=%0d exp 080 1", bus.micro_pc, bus.stack_level);
        end
        step(3'd4, '0);
        n_checks++;
        if (bus.micro_pc !== 9'h011 || bus.stack_level !== 3'd0) begin
            n_errors++; $display("FAIL return got pc=%h lvl=%0d exp 011 0", bus.micro_pc, bus.stack_level);
        end
    endtask

    task automatic test_overflow();
        logic [ADDR_W-1:0] exp_ret [4];
        exp_ret[0] = 9'h104; exp_ret[1] = 9'h103; exp_ret[2] = 9'h102; exp_ret[3] = 9'h101;
        do_reset();
        step(3'd3, 9'h100);
        step(3'd3, 9'h101);
        step(3'd3, 9'h102);
        step(3'd3, 9'h103);
        step(3'd3, 9'h150);
        n_checks++;
        if (bus.stack_overflow !== 1'b1 || bus.stack_level !== 3'd4 || bus.micro_pc !== 9'h150) begin
            n_errors++;
            $display("FAIL overflow got ovf=%b lvl=%0d pc=%h exp 1 4 150", bus.stack_overflow, bus.stack_level, bus.micro_pc);
        end
        for (int i = 0; i < 4; i++) begin
            step(3'd4, '0);
            n_checks++;
            if (bus.micro_pc !== exp_ret[i]) begin
                n_errors++; $display("FAIL lifo_return%0d got %h exp %h", i, bus.micro_pc, exp_ret[i]);
            end
        end
        step(3'd4, '0);
        n_checks++;
        if (bus.stack_underflow !== 1'b1 || bus.stack_level !== 3'd0 || bus.micro_pc !== 9'h102) begin
            n_errors++;
            $display("FAIL underflow got udf=%b lvl=%0d pc=%h exp 1 0 102", bus.stack_underflow, bus.stack_level, bus.micro_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(3'd2, 9'h1FF);
        step(3'd0, '0);
        n_checks++;
        if (bus.micro_pc !== 9'h000) begin n_errors++; $display("FAIL wrap_next got %h exp 000", bus.micro_pc); end
        step(3'd2, 9'h1FE);
        drive(3'd1, 1'b1, 4'd5, '0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus.micro_pc !== 9'h003) begin n_errors++; $display("FAIL wrap_branch got %h exp 003", bus.micro_pc); end
    endtask

    task automatic test_wait();
        do_reset();
        step(3'd2, 9'h020);
        for (int i = 0; i < 3; i++) begin
            drive(3'd5, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
            tick();
            n_checks++;
            if (bus.micro_pc !== 9'h020) begin n_errors++; $display("FAIL wait_hold%0d got %h exp 020", i, bus.micro_pc); end
        end
        drive(3'd5, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus.micro_pc !== 9'h021) begin n_errors++; $display("FAIL wait_release got %h exp 021", bus.micro_pc); end
    endtask

    task automatic test_trap();
        do_reset();
        step(3'd2, 9'h033);
        drive(3'd3, 1'b0, '0, 9'h055, 1'b0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (bus.micro_pc !== 9'h033 || bus.stack_level !== 3'd0) begin
            n_errors++; $display("FAIL stall_hold got pc=%h lvl=%0d exp 033 0", bus.micro_pc, bus.stack_level);
        end
        drive(3'd3, 1'b0, '0, 9'h055, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (bus.micro_pc !== 9'h1F0 || bus.stack_level !== 3'd1) begin
            n_errors++; $display("FAIL trap_entry got pc=%h lvl=%0d exp 1f0 1", bus.micro_pc, bus.stack_level);
        end
        step(3'd4, '0);
        n_checks++;
        if (bus.micro_pc !== 9'h033) begin n_errors++; $display("FAIL trap_return got %h exp 033", bus.micro_pc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(3'd7, '0);
        step(3'd3, 9'h080);
        drive(3'd3, 1'b0, '0, 9'h0C0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.micro_pc !== 9'h000 || bus.next_pc !== 9'h000 || bus.stack_level !== 3'd0 ||
            bus.stack_underflow !== 1'b0 || bus.stack_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset got pc=%h npc=%h lvl=%0d udf=%b ovf=%b exp 000 000 0 0 0",
                     bus.micro_pc, bus.next_pc, bus.stack_level, bus.stack_underflow, bus.stack_overflow);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        tick();
        n_checks++;
        if (bus.micro_pc !== 9'h0C0 || bus.stack_level !== 3'd1) begin
            n_errors++; $display("FAIL post_reset_call got pc=%h lvl=%0d exp 0c0 1", bus.micro_pc, bus.stack_level);
        end
        for (int i = 0; i < 3; i++) step(3'd6, '0);
        drive(3'd3, 1'b0, '0, 9'h0D0, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (bus.stack_overflow !== 1'b1) begin n_errors++; $display("FAIL clear_vs_overflow got %b exp 1", bus.stack_overflow); end
        drive(3'd0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (bus.stack_overflow !== 1'b0) begin n_errors++; $display("FAIL clear_err got %b exp 0", bus.stack_overflow); end
    endtask

    task automatic test_random();
        int exp_npc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  9'($urandom_range(0, MASK)), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0));
            #1;
            exp_npc = predict_next();
            n_checks++;
            if (bus.next_pc !== ADDR_W'(exp_npc)) begin
                n_errors++; $display("FAIL rand_next_pc step %0d got %h exp %h", i, bus.next_pc, ADDR_W'(exp_npc));
            end
            tick();
            n_checks++;
            if (bus.micro_pc !== ADDR_W'(m_pc)) begin
                n_errors++; $display("FAIL rand_pc step %0d got %h exp %h", i, bus.micro_pc, ADDR_W'(m_pc));
            end
            n_checks++;
            if (bus.stack_level !== LVL_W'(m_stack.size())) begin
                n_errors++; $display("FAIL rand_level step %0d got %0d exp %0d", i, bus.stack_level, m_stack.size());
            end
            n_checks++;
            if (bus.stack_overflow !== m_ovf || bus.stack_underflow !== m_udf) begin
                n_errors++;
                $display("FAIL rand_flags step %0d got ovf=%b udf=%b exp ovf=%b udf=%b",
                         i, bus.stack_overflow, bus.stack_underflow, m_ovf, m_udf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_call_return();
        test_overflow();
        test_wrap();
        test_wait();
        test_trap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 Parameter ADDR_W, default 9, microcode address width.
REQ-002 Parameter DEPTH, default 4, return-stack entries; legal values 2..16.
REQ-003 Parameter OFF_W, default 4, branch offset width, less than ADDR_W.
REQ-004 Parameter RESET_PC, default 0, address after reset.
REQ-005 Parameter TRAP_PC, default 9'h1F0, trap entry address.
REQ-006 clock  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 op  in  3  sequencing operation for the current microword.
REQ-009 cond  in  1  branch/wait condition.
REQ-010 offset  in  OFF_W  relative branch offset, unsigned.
REQ-011 target  in  ADDR_W  absolute jump/call target.
REQ-012 trap_req  in  1  force trap entry this cycle.
REQ-013 stall  in  1  freeze the sequencer this cycle.
REQ-014 clear_err  in  1  clear sticky error flags.
REQ-015 micro_pc  out  ADDR_W  registered address of the current microword.
REQ-016 next_pc  out  ADDR_W  combinational address to be loaded at the next edge.
REQ-017 stack_level  out  $clog2(DEPTH+1)  number of valid stack entries.
REQ-018 stack_overflow  out  1  sticky; a push occurred while the stack was full.
REQ-019 stack_underflow  out  1  sticky; a pop or return occurred while the stack was empty.

Function
REQ-020 The op encoding SHALL be: 0 NEXT, 1 BRANCH, 2 JUMP, 3 CALL, 4 RETURN, 5 WAIT, 6 PUSH, 7 POP.
REQ-021 Priority SHALL be reset > trap_req > stall > op.
REQ-022 NEXT: next_pc = micro_pc+1; stack unchanged.
REQ-023 BRANCH: next_pc = micro_pc + zero-extended offset if cond=1, else micro_pc+1.
REQ-024 JUMP: next_pc = target.
REQ-025 CALL: next_pc = target; push micro_pc+1.
REQ-026 RETURN: next_pc = top of stack; pop.
REQ-027 WAIT: next_pc = micro_pc while cond=0; micro_pc+1 when cond=1.
REQ-028 PUSH: push micro_pc; next_pc = micro_pc+1.
REQ-029 POP: discard the top entry; next_pc = micro_pc+1.
REQ-030 trap_req=1: next_pc = TRAP_PC; push micro_pc, so RETURN re-executes the interrupted word; op and stall are ignored.
REQ-031 stall=1 without trap_req: next_pc = micro_pc; stack, level and flags are held.
REQ-032 All address arithmetic SHALL be modulo 2^ADDR_W; the maximum address plus 1 wraps to 0.
REQ-033 Push with the stack full: the oldest entry is discarded, the new entry becomes top, stack_level stays at DEPTH, and stack_overflow is set.
REQ-034 RETURN with the stack empty: next_pc = micro_pc+1, stack_level stays 0, and stack_underflow is set.
REQ-035 POP with the stack empty: stack_underflow is set; no other stack effect.
REQ-036 Pop after a full-stack push SHALL return entries in LIFO order; discarded entries are never returned.
REQ-037 clear_err clears both flags at the next edge; an error raised in the same cycle wins and the flag stays set.
REQ-038 micro_pc SHALL be loaded from next_pc on every non-reset edge; there is one cycle of latency from op to micro_pc.

Reset
REQ-039 reset=1 SHALL immediately force micro_pc=RESET_PC, stack_level=0, both flags=0, and all stack entries=0, independent of clock, including mid-CALL or mid-trap.
REQ-040 While reset=1, next_pc SHALL equal RESET_PC.
REQ-041 The first edge after reset deasserts SHALL apply op normally.

Verification
REQ-042 Reset, then micro_pc=0x010, CALL with target=0x080 -> micro_pc=0x080, level=1; then RETURN -> micro_pc=0x011, level=0.
REQ-043 DEPTH=4: five nested CALLs from 0x000, 0x100, 0x101, 0x102, 0x103 -> overflow=1, level=4; four RETURNs yield 0x104, 0x103, 0x102, 0x101; a fifth RETURN sets underflow.
REQ-044 micro_pc=0x1FF, NEXT -> micro_pc=0x000; BRANCH at 0x1FE with offset=5 and cond=1 -> 0x003.
REQ-045 WAIT at 0x020 with cond=0 for 3 cycles -> micro_pc holds 0x020; cond=1 -> 0x021.
REQ-046 trap_req and stall together at 0x033 -> micro_pc=0x1F0, level +1; RETURN -> 0x033.
REQ-047 reset asserted between clock edges during a CALL sequence -> outputs reach their reset values without a clock edge; clear_err together with a new overflow -> overflow stays 1.
